// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter sharing one line-granular main_mem port between
// the instruction-side (port 0) and data-side (port 1) cache controllers.
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter  int unsigned LINE_ADDR_LEN = 3,
    parameter  int unsigned ADDR_LEN      = 9,
    localparam int unsigned LINE_SIZE     = 1 << LINE_ADDR_LEN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                p0_rd_req,
    input  logic                p0_wr_req,
    input  logic [ADDR_LEN-1:0] p0_addr,
    input  logic [31:0]         p0_wr_line [LINE_SIZE],
    output logic [31:0]         p0_rd_line [LINE_SIZE],
    output logic                p0_gnt,
    input  logic                p1_rd_req,
    input  logic                p1_wr_req,
    input  logic [ADDR_LEN-1:0] p1_addr,
    input  logic [31:0]         p1_wr_line [LINE_SIZE],
    output logic [31:0]         p1_rd_line [LINE_SIZE],
    output logic                p1_gnt,
    output logic                mem_rd_req,
    output logic                mem_wr_req,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic [31:0]         mem_wr_line [LINE_SIZE],
    input  logic [31:0]         mem_rd_line [LINE_SIZE],
    input  logic                mem_gnt,
    output logic                busy,
    output logic                owner,
    output logic [31:0]         p0_txn_cnt,
    output logic [31:0]         p1_txn_cnt
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state;
    state_t              state_next;
    logic                last_grant;
    logic                cmd_wr;
    logic [ADDR_LEN-1:0] cmd_addr;
    logic [31:0]         cmd_line [LINE_SIZE];
    logic                p0_req;
    logic                p1_req;
    logic                grant_any;
    logic                grant_port;

    assign p0_req    = p0_rd_req | p0_wr_req;
    assign p1_req    = p1_rd_req | p1_wr_req;
    assign grant_any = p0_req | p1_req;

    // On a tie the port that did not win last time is chosen.
    assign grant_port = (p0_req && p1_req) ? ~last_grant : p1_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_any) state_next = BUSY;
            BUSY:    if (mem_gnt)   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy        = 1'b0;
        mem_rd_req  = 1'b0;
        mem_wr_req  = 1'b0;
        mem_addr    = '0;
        p0_gnt      = 1'b0;
        p1_gnt      = 1'b0;
        mem_wr_line = cmd_line;
        if (state == BUSY) begin
            busy       = 1'b1;
            mem_rd_req = ~cmd_wr;
            mem_wr_req = cmd_wr;
            mem_addr   = cmd_addr;
            p0_gnt     = mem_gnt & ~owner;
            p1_gnt     = mem_gnt & owner;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            owner      <= 1'b0;
            cmd_wr     <= 1'b0;
            cmd_addr   <= '0;
            cmd_line   <= '{default: '0};
            p0_rd_line <= '{default: '0};
            p1_rd_line <= '{default: '0};
            p0_txn_cnt <= '0;
            p1_txn_cnt <= '0;
        end else begin
            if (state == IDLE && grant_any) begin
                owner      <= grant_port;
                last_grant <= grant_port;
                // A write wins if a port raises both requests at once.
                if (grant_port) begin
                    cmd_wr   <= p1_wr_req;
                    cmd_addr <= p1_addr;
                    cmd_line <= p1_wr_line;
                end else begin
                    cmd_wr   <= p0_wr_req;
                    cmd_addr <= p0_addr;
                    cmd_line <= p0_wr_line;
                end
            end
            if (state == BUSY && mem_gnt) begin
                if (owner) begin
                    p1_txn_cnt <= p1_txn_cnt + 32'd1;
                    if (!cmd_wr) p1_rd_line <= mem_rd_line;
                end else begin
                    p0_txn_cnt <= p0_txn_cnt + 32'd1;
                    if (!cmd_wr) p0_rd_line <= mem_rd_line;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: behavioural main_mem, per-port request
// queues and a monitor applying the round-robin/one-at-a-time rules.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int unsigned LS = 8;
    localparam int unsigned AL = 9;
    localparam int unsigned LW = LS * 32;
    typedef logic [LW-1:0] line_t;
    typedef struct packed { logic wr; logic [AL-1:0] addr; line_t data; } op_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          p0_rd_req, p0_wr_req, p1_rd_req, p1_wr_req;
    logic [AL-1:0] p0_addr, p1_addr, mem_addr;
    logic [31:0]   p0_wr_line [LS];
    logic [31:0]   p1_wr_line [LS];
    logic [31:0]   p0_rd_line [LS];
    logic [31:0]   p1_rd_line [LS];
    logic [31:0]   mem_wr_line [LS];
    logic [31:0]   mem_rd_line [LS];
    logic          p0_gnt, p1_gnt, mem_rd_req, mem_wr_req, mem_gnt, busy, owner;
    logic [31:0]   p0_txn_cnt, p1_txn_cnt;

    always #5 clk = ~clk;

    mem_port_arbiter #(.LINE_ADDR_LEN(3), .ADDR_LEN(9)) dut (
        .clk(clk), .rst(rst),
        .p0_rd_req(p0_rd_req), .p0_wr_req(p0_wr_req), .p0_addr(p0_addr),
        .p0_wr_line(p0_wr_line), .p0_rd_line(p0_rd_line), .p0_gnt(p0_gnt),
        .p1_rd_req(p1_rd_req), .p1_wr_req(p1_wr_req), .p1_addr(p1_addr),
        .p1_wr_line(p1_wr_line), .p1_rd_line(p1_rd_line), .p1_gnt(p1_gnt),
        .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
        .mem_wr_line(mem_wr_line), .mem_rd_line(mem_rd_line), .mem_gnt(mem_gnt),
        .busy(busy), .owner(owner), .p0_txn_cnt(p0_txn_cnt), .p1_txn_cnt(p1_txn_cnt)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    line_t       mem [512];
    line_t       ref_mem [512];
    op_t         q0 [$];
    op_t         q1 [$];

    task automatic chk(input string name, input line_t got, input line_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    function automatic line_t flat(input logic [31:0] l [LS]);
        line_t r;
        for (int i = 0; i < LS; i++) r[i*32 +: 32] = l[i];
        return r;
    endfunction

    function automatic line_t rand_line();
        line_t r;
        for (int i = 0; i < LS; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic set_req(input int k, input logic wr, input logic [AL-1:0] a,
                           input line_t d, input bit viol);
        op_t o;
        o.wr = wr; o.addr = a; o.data = d;
        if (k == 0) begin
            p0_wr_req = wr; p0_rd_req = !wr || viol; p0_addr = a;
            for (int i = 0; i < LS; i++) p0_wr_line[i] = d[i*32 +: 32];
            q0.push_back(o);
        end else begin
            p1_wr_req = wr; p1_rd_req = !wr || viol; p1_addr = a;
            for (int i = 0; i < LS; i++) p1_wr_line[i] = d[i*32 +: 32];
            q1.push_back(o);
        end
    endtask

    task automatic clr_req(input int k);
        if (k == 0) begin p0_rd_req = 1'b0; p0_wr_req = 1'b0; end
        else        begin p1_rd_req = 1'b0; p1_wr_req = 1'b0; end
    endtask

    // Returns at posedge+1 after the port's gnt; optionally scrambles the
    // port's inputs while its own transaction is in flight.
    task automatic wait_gnt(input int k, input bit scr);
        bit seen = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            @(negedge clk);
            if ((k == 0) ? p0_gnt : p1_gnt) seen = 1'b1;
            else if (scr && busy && (owner == k[0]) && $urandom_range(0, 1) == 1) begin
                if (k == 0) begin
                    p0_addr = AL'($urandom);
                    for (int i = 0; i < LS; i++) p0_wr_line[i] = $urandom;
                end else begin
                    p1_addr = AL'($urandom);
                    for (int i = 0; i < LS; i++) p1_wr_line[i] = $urandom;
                end
            end
        end
        chk($sformatf("gnt_arrived_p%0d", k), seen, 1'b1);
        @(posedge clk); #1;
    endtask

    // Behavioural main_mem: random or forced latency, one gnt pulse per request.
    int force_lat = -1;
    int lat_cnt   = 0;
    bit pend      = 1'b0;
    initial begin
        mem_gnt = 1'b0;
        for (int i = 0; i < LS; i++) mem_rd_line[i] = '0;
        forever begin
            @(posedge clk); #1;
            mem_gnt = 1'b0;
            for (int i = 0; i < LS; i++) mem_rd_line[i] = $urandom;
            if (mem_rd_req || mem_wr_req) begin
                if (!pend) begin
                    pend    = 1'b1;
                    lat_cnt = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
                end
                if (lat_cnt == 0) begin
                    pend    = 1'b0;
                    mem_gnt = 1'b1;
                    if (mem_wr_req) mem[mem_addr] = flat(mem_wr_line);
                    else for (int i = 0; i < LS; i++) mem_rd_line[i] = mem[mem_addr][i*32 +: 32];
                end else begin
                    lat_cnt--;
                end
            end else begin
                pend = 1'b0;
            end
        end
    end

    // Monitor: reference model of the arbitration rules plus scoreboard pops.
    bit          m_busy, m_own, last_served, post_v, post_k, r0, r1;
    op_t         cur;
    line_t       exp_rd [2];
    int unsigned exp_cnt [2];
    int unsigned wait_cnt [2];
    always @(negedge clk) begin
        if (rst) begin
            m_busy = 0; m_own = 0; last_served = 1; post_v = 0;
            exp_rd[0] = '0; exp_rd[1] = '0; exp_cnt[0] = 0; exp_cnt[1] = 0;
            wait_cnt[0] = 0; wait_cnt[1] = 0;
            q0.delete(); q1.delete();
        end else if (m_busy) begin
            chk("busy_in_txn", busy, 1'b1);
            chk("owner_in_txn", owner, m_own);
            chk("mem_addr", mem_addr, cur.addr);
            chk("mem_wr_req", mem_wr_req, cur.wr);
            chk("mem_rd_req", mem_rd_req, !cur.wr);
            if (cur.wr) chk("mem_wr_line", flat(mem_wr_line), cur.data);
            chk("p0_gnt", p0_gnt, mem_gnt && !m_own);
            chk("p1_gnt", p1_gnt, mem_gnt && m_own);
            if (mem_gnt) begin
                if (cur.wr) ref_mem[cur.addr] = cur.data;
                else        exp_rd[m_own] = ref_mem[cur.addr];
                exp_cnt[m_own]++;
                wait_cnt[m_own] = 0;
                if ((m_own ? q0.size() : q1.size()) != 0) begin
                    wait_cnt[!m_own]++;
                    chk("starvation_bound", wait_cnt[!m_own] <= 1, 1'b1);
                end
                post_v = 1; post_k = m_own; m_busy = 0;
            end
        end else begin
            chk("idle_busy", busy, 1'b0);
            chk("idle_mem_req", {mem_rd_req, mem_wr_req}, 2'b00);
            chk("idle_mem_addr", mem_addr, '0);
            chk("idle_gnt", {p0_gnt, p1_gnt}, 2'b00);
            chk("idle_owner", owner, m_own);
            if (post_v) begin
                chk($sformatf("rd_line_p%0d", post_k),
                    post_k ? flat(p1_rd_line) : flat(p0_rd_line), exp_rd[post_k]);
                chk("p0_txn_cnt", p0_txn_cnt, exp_cnt[0]);
                chk("p1_txn_cnt", p1_txn_cnt, exp_cnt[1]);
                post_v = 0;
            end
            r0 = p0_rd_req | p0_wr_req;
            r1 = p1_rd_req | p1_wr_req;
            if (r0 || r1) begin
                m_own = (r0 && r1) ? !last_served : r1;
                last_served = m_own;
                if ((m_own ? q1.size() : q0.size()) == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL scoreboard_empty: port %0d requesting with no queued op", m_own);
                end else begin
                    cur = m_own ? q1.pop_front() : q0.pop_front();
                    m_busy = 1;
                end
            end
        end
    end

    task automatic rand_driver(input int k, input int n);
        bit            b2b = 1'b0;
        logic          wr;
        logic [AL-1:0] a;
        for (int i = 0; i < n; i++) begin
            if (!b2b) begin @(posedge clk); #1; end
            wr = 1'($urandom_range(0, 1));
            a  = AL'($urandom_range(0, 15));
            set_req(k, wr, a, rand_line(), wr && ($urandom_range(0, 7) == 0));
            wait_gnt(k, 1'b1);
            b2b = ($urandom_range(0, 2) == 0);
            if (!b2b) begin
                clr_req(k);
                repeat ($urandom_range(0, 2)) @(posedge clk);
            end
        end
        clr_req(k);
    endtask

    line_t init_5a, init_d3, seq_line;
    time   t0, t1;
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 512; i++) begin
            mem[i] = rand_line();
            ref_mem[i] = mem[i];
        end
        init_5a = mem[9'h05A];
        init_d3 = mem[9'h0D3];
        for (int i = 0; i < LS; i++) seq_line[i*32 +: 32] = i;
        rst = 1'b1;
        p0_rd_req = 0; p0_wr_req = 0; p0_addr = '0;
        p1_rd_req = 0; p1_wr_req = 0; p1_addr = '0;
        for (int i = 0; i < LS; i++) begin p0_wr_line[i] = '0; p1_wr_line[i] = '0; end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset then idle
        repeat (10) @(negedge clk);
        chk("reset_counters", {p0_txn_cnt, p1_txn_cnt}, '0);
        chk("reset_rd_lines", flat(p0_rd_line) | flat(p1_rd_line), '0);
        chk("reset_owner", owner, 1'b0);

        // Tie after reset: p0 write first, p1 read second, then next tie to p0
        for (int rep = 0; rep < 2; rep++) begin
            @(posedge clk); #1;
            set_req(0, 1'b1, AL'(9'h100 + rep), rand_line(), 1'b0);
            set_req(1, 1'b0, AL'(9'h110 + rep), '0, 1'b0);
            fork
                begin wait_gnt(0, 1'b0); t0 = $time; clr_req(0); end
                begin wait_gnt(1, 1'b0); t1 = $time; clr_req(1); end
            join
            chk("tie_p0_first", t0 < t1, 1'b1);
        end

        // Single read from a fresh reset
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        set_req(0, 1'b0, 9'h05A, '0, 1'b0);
        wait_gnt(0, 1'b0);
        clr_req(0);
        @(negedge clk);
        chk("single_rd_line", flat(p0_rd_line), init_5a);
        chk("single_rd_cnt", p0_txn_cnt, 32'd1);

        // Write-back then fill on p1, read back through p0
        @(posedge clk); #1;
        set_req(1, 1'b1, 9'h013, seq_line, 1'b0);
        wait_gnt(1, 1'b0);
        set_req(1, 1'b0, 9'h0D3, '0, 1'b0);
        wait_gnt(1, 1'b0);
        clr_req(1);
        @(negedge clk);
        chk("fill_p1_rd_line", flat(p1_rd_line), init_d3);
        @(posedge clk); #1;
        set_req(0, 1'b0, 9'h013, '0, 1'b0);
        wait_gnt(0, 1'b0);
        clr_req(0);
        @(negedge clk);
        chk("readback_p0", flat(p0_rd_line), seq_line);

        // p1 write in flight, p0 waits with a wandering address
        force_lat = 4;
        @(posedge clk); #1;
        set_req(1, 1'b1, 9'h077, rand_line(), 1'b0);
        for (int c = 0; c < 50 && !busy; c++) @(negedge clk);
        @(posedge clk); #1;
        set_req(0, 1'b0, 9'h0AA, '0, 1'b0);
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (p1_gnt) break;
            p0_addr = AL'($urandom);
        end
        p0_addr = 9'h0AA;
        @(posedge clk); #1;
        clr_req(1);
        wait_gnt(0, 1'b0);
        clr_req(0);
        force_lat = -1;

        // Randomized concurrent traffic
        fork
            rand_driver(0, 80);
            rand_driver(1, 80);
        join
        repeat (4) @(posedge clk);

        // Reset in the third BUSY cycle of a slow read
        force_lat = 10;
        @(posedge clk); #1;
        set_req(0, 1'b0, 9'h021, '0, 1'b0);
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (busy) break;
        end
        chk("midop_busy_seen", busy, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        clr_req(0);
        @(negedge clk);
        chk("midop_no_gnt", {p0_gnt, p1_gnt}, 2'b00);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midop_mem_req_low", {mem_rd_req, mem_wr_req}, 2'b00);
        chk("midop_no_gnt_after", {p0_gnt, p1_gnt}, 2'b00);
        chk("midop_counters", {p0_txn_cnt, p1_txn_cnt}, '0);
        force_lat = -1;
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
